// File: rtl/stream_mux_pkg.sv
// Shared types for the two-input round-robin stream multiplexer.
package stream_mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_A,
        LOCK_B
    } lock_state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter that keeps the grant on one input until its packet's last beat.
module rr_arb2
    import stream_mux_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    input  logic a_last,
    input  logic b_last,
    input  logic load,
    output logic grant_a,
    output logic grant_b
);

    lock_state_e state_q, state_d;
    src_e        prio_q, prio_d;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        state_d = state_q;
        prio_d  = prio_q;

        unique case (state_q)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant_a = (prio_q == SRC_A);
                    grant_b = (prio_q == SRC_B);
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end
            end
            LOCK_A:  grant_a = a_valid;
            LOCK_B:  grant_b = b_valid;
            default: state_d = IDLE;
        endcase

        // Priority only moves when a packet completes, so stalled beats never rotate it.
        if (load && grant_a) begin
            if (a_last) begin
                state_d = IDLE;
                prio_d  = SRC_B;
            end else begin
                state_d = LOCK_A;
            end
        end else if (load && grant_b) begin
            if (b_last) begin
                state_d = IDLE;
                prio_d  = SRC_A;
            end else begin
                state_d = LOCK_B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= SRC_A;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: rtl/stream_mux2_rr.sv
// Merges two valid/ready packet streams onto one registered output with packet-locked round robin.
module stream_mux2_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);

    logic             load;
    logic             grant_a, grant_b;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    src_e             out_src_q, out_src_d;

    assign load = ~out_valid_q | out_ready;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_last  (a_last),
        .b_last  (b_last),
        .load    (load),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // Ready is masked during reset so no beat is consumed that the reset would then discard.
    assign a_ready = load & grant_a & ~rst;
    assign b_ready = load & grant_b & ~rst;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (a_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = a_data;
            out_last_d  = a_last;
            out_src_d   = SRC_A;
        end else if (b_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = b_data;
            out_last_d  = b_last;
            out_src_d   = SRC_B;
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= SRC_A;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux2_rr.sv
// Self-checking bench for stream_mux2_rr: directed scenarios plus a randomized run against a model.
module tb_stream_mux2_rr;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, a_last, a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid, b_last, b_ready;
    logic [WIDTH-1:0] b_data;
    logic             out_valid, out_last, out_src, out_ready;
    logic [WIDTH-1:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: which input owns the output (-1 none), who wins a tie, output register.
    int               m_owner;
    int               m_prio;
    logic             m_ov, m_ol, m_os;
    logic [WIDTH-1:0] m_od;

    // Values captured just before each edge.
    logic exp_ar, exp_br, obs_ar, obs_br, obs_fire;

    always #5 clk = ~clk;

    stream_mux2_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    function automatic void model_grant(output logic ga, output logic gb);
        ga = 1'b0;
        gb = 1'b0;
        if (m_owner == 0) ga = a_valid;
        else if (m_owner == 1) gb = b_valid;
        else if (a_valid && b_valid) begin
            ga = (m_prio == 0);
            gb = (m_prio == 1);
        end else begin
            ga = a_valid;
            gb = b_valid;
        end
    endfunction

    // Advance one clock: record ready/fire expectations and observations, then update the model.
    task automatic tick();
        logic ga, gb, ld;
        #1;
        model_grant(ga, gb);
        ld       = !m_ov || out_ready;
        exp_ar   = !rst && ld && ga;
        exp_br   = !rst && ld && gb;
        obs_ar   = a_ready;
        obs_br   = b_ready;
        obs_fire = out_valid && out_ready;
        @(posedge clk);
        if (rst) begin
            m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
            m_owner = -1; m_prio = 0;
        end else if (exp_ar) begin
            m_ov = 1; m_od = a_data; m_ol = a_last; m_os = 0;
            if (a_last) begin m_owner = -1; m_prio = 1; end
            else m_owner = 0;
        end else if (exp_br) begin
            m_ov = 1; m_od = b_data; m_ol = b_last; m_os = 1;
            if (b_last) begin m_owner = -1; m_prio = 0; end
            else m_owner = 1;
        end else if (ld) begin
            m_ov = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_data = '0; a_last = 0;
        b_valid = 0; b_data = '0; b_last = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; out_ready = 1;
        a_valid = 1; a_data = 8'h3C; a_last = 1;
        b_valid = 1; b_data = 8'hC3; b_last = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || obs_ar !== 1'b0 || obs_br !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc%0d: valid=%b a_ready=%b b_ready=%b, required 0/0/0",
                         i, out_valid, obs_ar, obs_br);
            end
        end
        n_cmp++;
        if (out_data !== '0 || out_last !== 1'b0 || out_src !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs: data=%h last=%b src=%b, required 00/0/0",
                     out_data, out_last, out_src);
        end
        rst = 0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h3C) begin
            n_err++;
            $display("FAIL reset_first_grant: valid=%b src=%b data=%h, required 1/0/3c",
                     out_valid, out_src, out_data);
        end
    endtask

    task automatic test_alternation();
        logic exp_src;
        idle_inputs();
        do_reset();
        out_ready = 1;
        a_valid = 1; a_data = 8'h11; a_last = 1;
        b_valid = 1; b_data = 8'h22; b_last = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_src = (i % 2 == 1);
            n_cmp++;
            if (out_valid !== 1'b1 || out_src !== exp_src
                || out_data !== (exp_src ? 8'h22 : 8'h11)) begin
                n_err++;
                $display("FAIL alternation beat%0d: valid=%b src=%b data=%h, required 1/%b/%h",
                         i, out_valid, out_src, out_data, exp_src, exp_src ? 8'h22 : 8'h11);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2; exp_d[3] = 8'hB0;
        idle_inputs();
        do_reset();
        out_ready = 1;
        b_valid = 1; b_data = 8'hB0; b_last = 1;
        for (int i = 0; i < 4; i++) begin
            a_valid = (i < 3);
            a_data  = 8'hA0 + 8'(i);
            a_last  = (i == 2);
            tick();
            if (i < 3) begin
                n_cmp++;
                if (obs_br !== 1'b0) begin
                    n_err++;
                    $display("FAIL lock_b_ready cyc%0d: b_ready=%b, required 0", i, obs_br);
                end
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_src !== (i == 3)) begin
                n_err++;
                $display("FAIL lock_seq beat%0d: valid=%b data=%h src=%b, required 1/%h/%b",
                         i, out_valid, out_data, out_src, exp_d[i], i == 3);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int         accepts, fires;
        idle_inputs();
        do_reset();
        held = 8'($urandom);
        out_ready = 1;
        a_valid = 1; a_data = held; a_last = 1;
        b_valid = 1; b_data = 8'($urandom); b_last = 1;
        tick();
        accepts = int'(obs_ar) + int'(obs_br);
        fires = 0;
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== held || out_src !== 1'b0
                || obs_ar !== 1'b0 || obs_br !== 1'b0) begin
                n_err++;
                $display("FAIL stall cyc%0d: valid=%b data=%h src=%b ready=%b%b, required 1/%h/0/00",
                         i, out_valid, out_data, out_src, obs_ar, obs_br, held);
            end
        end
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin a_valid = 0; b_valid = 0; end
            tick();
            accepts += int'(obs_ar) + int'(obs_br);
            fires += int'(obs_fire);
        end
        n_cmp++;
        if (fires !== accepts || fires !== 4) begin
            n_err++;
            $display("FAIL bp_count: out transfers=%0d, required %0d (input beats) and 4",
                     fires, accepts);
        end
    endtask

    task automatic test_lock_bubbles();
        idle_inputs();
        do_reset();
        out_ready = 1;
        b_valid = 1; b_data = 8'h55; b_last = 1;
        a_valid = 1; a_data = 8'h01; a_last = 0;
        tick();
        a_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs_br !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL bubble cyc%0d: b_ready=%b out_valid=%b, required 0/0",
                         i, obs_br, out_valid);
            end
        end
        a_valid = 1; a_data = 8'h02; a_last = 1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h02 || out_src !== 1'b0 || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL bubble_resume: valid=%b data=%h src=%b last=%b, required 1/02/0/1",
                     out_valid, out_data, out_src, out_last);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || out_src !== 1'b1) begin
            n_err++;
            $display("FAIL bubble_then_b: valid=%b data=%h src=%b, required 1/55/1",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_reset_mid_packet();
        idle_inputs();
        do_reset();
        out_ready = 1;
        b_valid = 1; b_data = 8'h77; b_last = 0;
        tick();
        out_ready = 0;
        rst = 1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midpkt_reset: out_valid=%b, required 0", out_valid);
        end
        rst = 0; out_ready = 1;
        a_valid = 1; a_data = 8'h9A; a_last = 1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 8'h9A) begin
            n_err++;
            $display("FAIL midpkt_regrant: valid=%b src=%b data=%h, required 1/0/9a",
                     out_valid, out_src, out_data);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a_valid   = ($urandom_range(3, 0) != 0);
            a_data    = 8'($urandom);
            a_last    = ($urandom_range(2, 0) == 0);
            b_valid   = ($urandom_range(3, 0) != 0);
            b_data    = 8'($urandom);
            b_last    = ($urandom_range(2, 0) == 0);
            out_ready = ($urandom_range(3, 0) != 0);
            tick();
            n_cmp++;
            if (obs_ar !== exp_ar || obs_br !== exp_br || out_valid !== m_ov
                || (m_ov && (out_data !== m_od || out_last !== m_ol || out_src !== m_os))) begin
                n_err++;
                $display("FAIL random cyc%0d: rdy=%b%b v=%b d=%h l=%b s=%b, required %b%b %b %h %b %b",
                         i, obs_ar, obs_br, out_valid, out_data, out_last, out_src,
                         exp_ar, exp_br, m_ov, m_od, m_ol, m_os);
            end
        end
    endtask

    initial begin
        m_owner = -1; m_prio = 0;
        m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
        idle_inputs();
        rst = 1; out_ready = 1;
        test_reset();
        test_alternation();
        test_packet_lock();
        test_backpressure();
        test_lock_bubbles();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
